pll_dyn_ctrl: RTL
=================

PLL_DYN_CTRL -- requirements
Module: pll_dyn_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_ODIV, default 24, meaning the CLKOUT0 divider applied after reset (legal 2..127).
REQ-002 SHALL have parameter RST_CYCLES, default 16, meaning the number of clkin cycles pll_reset is held high per reset pulse.
REQ-003 SHALL have parameter GATE_CYCLES, default 4, meaning the number of guard cycles before and after a divider change while CLKOUT0 is gated.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 50000, meaning the maximum clkin cycles allowed in WAIT_LOCK (1 ms at 50 MHz).
REQ-005 SHALL have parameter MAX_RETRY, default 3, meaning the number of consecutive lock timeouts tolerated before FAIL.
REQ-006 SHALL have port clkin, input, 1 bit: the 50 MHz reference clock and the only clock of the block.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have ports req_valid (input, 1), req_odiv (input, 7) and req_ready (output, 1), forming a valid/ready divider-change request.
REQ-009 SHALL have port done, output, 1 bit: a one-cycle pulse when a request completes with lock.
REQ-010 SHALL have port err, output, 1 bit: a one-cycle pulse on an illegal request or a lock timeout.
REQ-011 SHALL have port fail, output, 1 bit: sticky; retries are exhausted.
REQ-012 SHALL have port clk_ok, output, 1 bit: CLKOUT0 is locked, ungated and stable.
REQ-013 SHALL have port pll_lock, input, 1 bit: the PLL LOCK signal, asynchronous to clkin.
REQ-014 SHALL have port pll_reset, output, 1 bit: drives the PLL RESET input.
REQ-015 SHALL have port pll_odsel0, output, 7 bits: the dynamic ODIV0 value, carrying the divider value directly.
REQ-016 SHALL have port pll_enclk0, output, 1 bit: drives ENCLK0.

Function
REQ-017 SHALL synchronise pll_lock through two flops before any use (lock_s).
REQ-018 SHALL implement the states PWRUP_RST, WAIT_LOCK, SETTLE, IDLE, GATE, APPLY, CHG_RST and FAIL.
REQ-019 SHALL assert req_ready only in IDLE with fail low; a handshake occurs when req_valid and req_ready are both high on a rising edge.
REQ-020 SHALL, on a handshake with req_odiv < 2, pulse err the next cycle, stay in IDLE and leave pll_odsel0 unchanged.
REQ-021 SHALL, on a legal handshake, latch req_odiv and enter GATE, driving pll_enclk0=0 and clk_ok=0 from the next cycle.
REQ-022 SHALL make GATE last GATE_CYCLES cycles; APPLY then loads pll_odsel0 with the latched value and lasts 1 cycle; CHG_RST follows.
REQ-023 SHALL, in PWRUP_RST and CHG_RST, hold pll_reset=1 for exactly RST_CYCLES cycles, then enter WAIT_LOCK with pll_reset=0.
REQ-024 SHALL, in WAIT_LOCK, count cycles; lock_s=1 enters SETTLE and clears the retry count.
REQ-025 SHALL, when the WAIT_LOCK counter reaches LOCK_TIMEOUT, pulse err, increment retry and re-enter CHG_RST; if retry reaches MAX_RETRY it instead enters FAIL.
REQ-026 SHALL make SETTLE last GATE_CYCLES cycles with lock_s continuously high, else return to WAIT_LOCK (timeout counter restarts); on exit set pll_enclk0=1, clk_ok=1 and enter IDLE, pulsing done only if the entry path was a request.
REQ-027 SHALL, in IDLE, treat lock_s=0 as lock loss: clear clk_ok, set pll_enclk0=0 and enter CHG_RST with the current divider, with no done pulse on recovery.
REQ-028 SHALL make FAIL absorbing until reset: fail=1, pll_reset=1, pll_enclk0=0, req_ready=0.
REQ-029 SHALL ignore req_valid in every state other than IDLE; a request is never queued.
REQ-030 SHALL drive done and err registered, never both high in the same cycle, and never overlapping a handshake acceptance.
REQ-031 SHALL size counters to hold max(LOCK_TIMEOUT, RST_CYCLES, GATE_CYCLES) without wrap; counters clear on every state entry.

Reset
REQ-032 SHALL, while reset is high, asynchronously force state=PWRUP_RST, pll_reset=1, pll_enclk0=0, pll_odsel0=DEFAULT_ODIV, req_ready=0, done=0, err=0, fail=0, clk_ok=0, retry=0, counters=0 and the synchroniser flops to 0.
REQ-033 SHALL, on reset deassertion (including mid-change or in FAIL), restart the power-up sequence with DEFAULT_ODIV, discarding any latched request.

Verification
REQ-034 SHALL pass this scenario: reset released, lock rises 100 cycles after pll_reset falls -> pll_reset high exactly 16 cycles, clk_ok=1 and req_ready=1 about 4+2 cycles after lock, no done pulse.
REQ-035 SHALL pass this scenario: in IDLE, request odiv=12 -> pll_enclk0 low 4 cycles before pll_odsel0=12, 16-cycle pll_reset, done pulse after relock, pll_odsel0 stays 12.
REQ-036 SHALL pass this scenario: request odiv=1, then odiv=0 -> err pulse each, pll_odsel0 unchanged, clk_ok stays 1.
REQ-037 SHALL pass this scenario: lock held low -> err every 50016 cycles, fail=1 after the 3rd timeout, req_ready=0 until reset.
REQ-038 SHALL pass this scenario: lock drops 5 cycles in IDLE -> clk_ok=0, reset pulse, relock with unchanged divider, no done pulse.
REQ-039 SHALL pass this scenario: reset asserted during CHG_RST with odiv=12 -> outputs at reset values immediately, power-up resumes with pll_odsel0=24.

Source files
------------

// File: rtl/pll_dyn_ctrl.sv
// Dynamic CLKOUT0 divider controller: power-up PLL reset, lock supervision with
// bounded retries, and divider changes with CLKOUT0 gated around a PLL reset.
module pll_dyn_ctrl #(
  parameter int DEFAULT_ODIV = 24,
  parameter int RST_CYCLES   = 16,
  parameter int GATE_CYCLES  = 4,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [6:0] req_odiv,
  output logic       req_ready,
  output logic       done,
  output logic       err,
  output logic       fail,
  output logic       clk_ok,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [6:0] pll_odsel0,
  output logic       pll_enclk0
);

  localparam int CNT_MAX0 = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > GATE_CYCLES) ? CNT_MAX0 : GATE_CYCLES;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int RW       = $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] GATE_LAST = CW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [6:0]    ODIV_RST  = 7'(DEFAULT_ODIV);

  typedef enum logic [2:0] {
    PWRUP_RST, WAIT_LOCK, SETTLE, IDLE, GATE, APPLY, CHG_RST, FAIL
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [RW-1:0]   r_retry, w_retry_nx;
  logic [6:0]      r_odiv_lat, w_odiv_lat_nx;
  logic [6:0]      r_odsel, w_odsel_nx;
  logic            r_from_req, w_from_req_nx;
  logic [1:0]      r_sync;
  logic            r_pll_reset, r_enclk0, r_clk_ok, r_ready, r_done, r_err, r_fail;
  logic            w_done_nx, w_err_nx, w_lock_s, w_hs;

  assign w_lock_s = r_sync[1];
  assign w_hs     = req_valid && r_ready;

  always_comb begin
    w_next        = r_state;
    w_retry_nx    = r_retry;
    w_odiv_lat_nx = r_odiv_lat;
    w_odsel_nx    = r_odsel;
    w_from_req_nx = r_from_req;
    w_done_nx     = 1'b0;
    w_err_nx      = 1'b0;
    case (r_state)
      PWRUP_RST, CHG_RST: begin
        if (r_cnt == RST_LAST) w_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (w_lock_s) begin
          w_next     = SETTLE;
          w_retry_nx = '0;
        end else if (r_cnt == TO_LAST) begin
          w_err_nx   = 1'b1;
          w_retry_nx = r_retry + 1'b1;
          w_next     = (w_retry_nx == RETRY_MAX) ? FAIL : CHG_RST;
        end
      end
      SETTLE: begin
        if (!w_lock_s) begin
          w_next = WAIT_LOCK;
        end else if (r_cnt == GATE_LAST) begin
          w_next        = IDLE;
          w_done_nx     = r_from_req;
          w_from_req_nx = 1'b0;
        end
      end
      IDLE: begin
        // A request accepted in the same cycle as a lock loss still wins;
        // its own PLL reset will recover lock anyway.
        if (w_hs) begin
          if (req_odiv < 7'd2) begin
            w_err_nx = 1'b1;
            if (!w_lock_s) w_next = CHG_RST;
          end else begin
            w_odiv_lat_nx = req_odiv;
            w_from_req_nx = 1'b1;
            w_next        = GATE;
          end
        end else if (!w_lock_s) begin
          w_next = CHG_RST;
        end
      end
      GATE: begin
        if (r_cnt == GATE_LAST) begin
          w_next     = APPLY;
          w_odsel_nx = r_odiv_lat;
        end
      end
      APPLY:   w_next = CHG_RST;
      FAIL:    w_next = FAIL;
      default: w_next = PWRUP_RST;
    endcase
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_state    <= PWRUP_RST;
      r_cnt      <= '0;
      r_retry    <= '0;
      r_odiv_lat <= ODIV_RST;
      r_odsel    <= ODIV_RST;
      r_from_req <= 1'b0;
      r_sync     <= 2'b00;
    end else begin
      r_state    <= w_next;
      r_retry    <= w_retry_nx;
      r_odiv_lat <= w_odiv_lat_nx;
      r_odsel    <= w_odsel_nx;
      r_from_req <= w_from_req_nx;
      r_sync     <= {r_sync[0], pll_lock};
      if (w_next != r_state) r_cnt <= '0;
      else if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Outputs are registered from the next state; ready drops during a done/err
  // pulse so a pulse never coincides with an accepted handshake.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_pll_reset <= 1'b1;
      r_enclk0    <= 1'b0;
      r_clk_ok    <= 1'b0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_pll_reset <= (w_next == PWRUP_RST) || (w_next == CHG_RST) || (w_next == FAIL);
      r_enclk0    <= (w_next == IDLE);
      r_clk_ok    <= (w_next == IDLE);
      r_ready     <= (w_next == IDLE) && !w_done_nx && !w_err_nx;
      r_done      <= w_done_nx;
      r_err       <= w_err_nx;
      r_fail      <= (w_next == FAIL);
    end
  end

  assign req_ready  = r_ready;
  assign done       = r_done;
  assign err        = r_err;
  assign fail       = r_fail;
  assign clk_ok     = r_clk_ok;
  assign pll_reset  = r_pll_reset;
  assign pll_odsel0 = r_odsel;
  assign pll_enclk0 = r_enclk0;

endmodule
